// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int REG_ZERO       = 0;

    typedef struct packed {
        logic                      valid;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; R1 is forced once R0 has won MAX_STREAK times
// in a row while R1 was waiting.
module rr_arb2 #(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    if (MAX_STREAK < 1) begin : g_bad_streak
        $error("MAX_STREAK must be at least 1");
    end

    logic                last_grant;
    logic [STREAK_W-1:0] streak;
    logic                force1;

    assign force1 = valid1 && (streak == STREAK_W'(MAX_STREAK));

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (valid0 && valid1) begin
                grant1 = force1 || !last_grant;
                grant0 = !grant1;
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    // last_grant resets to R1 so that R0 wins the first conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            streak     <= '0;
        end else begin
            if (grant1 || !valid1) begin
                streak <= '0;
            end else if (grant0 && streak != STREAK_W'(MAX_STREAK)) begin
                streak <= streak + 1'b1;
            end
            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/register.sv
// Generic enabled register with synchronous reset to INIT; the read value is
// forced to INIT while reset is high so consumers see a cleared output at once.
module Register #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= INIT;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = rst ? INIT : q_reg;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (R0) and the
// long-latency unit (R1); one registered write per cycle, x0 writes dropped.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_STREAK = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Req0Valid,
    input  logic [ADDR_WIDTH-1:0] i_Req0Addr,
    input  logic [DATA_WIDTH-1:0] i_Req0Data,
    output logic                  o_Req0Ready,
    input  logic                  i_Req1Valid,
    input  logic [ADDR_WIDTH-1:0] i_Req1Addr,
    input  logic [DATA_WIDTH-1:0] i_Req1Data,
    output logic                  o_Req1Ready,
    output logic                  o_WrEnable,
    output logic [ADDR_WIDTH-1:0] o_WrAddr,
    output logic [DATA_WIDTH-1:0] o_WrData,
    output logic [ADDR_WIDTH-1:0] o_PendAddr,
    output logic                  o_PendValid
);

    logic                  grant0;
    logic                  grant1;
    logic                  any_grant;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] data_p0;
    logic                  wr_en_p0;
    logic                  wr_en_p1;

    rr_arb2 #(
        .MAX_STREAK(MAX_STREAK)
    ) u_arb (
        .clk   (i_Clock),
        .rst   (i_Reset),
        .valid0(i_Req0Valid),
        .valid1(i_Req1Valid),
        .grant0(grant0),
        .grant1(grant1)
    );

    assign o_Req0Ready = grant0;
    assign o_Req1Ready = grant1;
    assign any_grant   = grant0 || grant1;

    assign addr_p0  = grant1 ? i_Req1Addr : i_Req0Addr;
    assign data_p0  = grant1 ? i_Req1Data : i_Req0Data;
    assign wr_en_p0 = any_grant && (addr_p0 != ADDR_WIDTH'(REG_ZERO));

    // ---- p0 -> p1: registered write port ----
    // The strobe register loads every cycle so it falls back to 0 without a grant
    Register #(.WIDTH(1), .INIT(1'b0)) u_wr_en (
        .clk(i_Clock), .rst(i_Reset), .en(1'b1), .d(wr_en_p0), .q(wr_en_p1)
    );

    Register #(.WIDTH(ADDR_WIDTH), .INIT('0)) u_wr_addr (
        .clk(i_Clock), .rst(i_Reset), .en(any_grant), .d(addr_p0), .q(o_WrAddr)
    );

    Register #(.WIDTH(DATA_WIDTH), .INIT('0)) u_wr_data (
        .clk(i_Clock), .rst(i_Reset), .en(any_grant), .d(data_p0), .q(o_WrData)
    );

    assign o_WrEnable  = wr_en_p1;
    assign o_PendValid = wr_en_p1;
    assign o_PendAddr  = o_WrAddr;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference arbiter predicts the
// grants, expected writes are queued and compared one cycle later.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int MS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        rdy0, rdy1, wen, pvalid;
    logic [4:0]  waddr, paddr;
    logic [31:0] wdata;

    int n_checks = 0;
    int n_errors = 0;

    wr_req_t exp_q[$];
    logic    m_last;
    int      m_streak;
    logic    g0, g1;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_STREAK(MS)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Req0Valid(v0),
        .i_Req0Addr (a0),
        .i_Req0Data (d0),
        .o_Req0Ready(rdy0),
        .i_Req1Valid(v1),
        .i_Req1Addr (a1),
        .i_Req1Data (d1),
        .o_Req1Ready(rdy1),
        .o_WrEnable (wen),
        .o_WrAddr   (waddr),
        .o_WrData   (wdata),
        .o_PendAddr (paddr),
        .o_PendValid(pvalid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: called at a negedge with inputs already driven.
    task automatic step();
        wr_req_t e;
        wr_req_t n;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (v0 && v1) begin
                g1 = (m_streak >= MS) || (m_last == 1'b0);
                g0 = !g1;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        if (rst) begin
            chk("rst_wen", 32'(wen), 32'd0);
            chk("rst_pvalid", 32'(pvalid), 32'd0);
            chk("rst_addr", 32'(waddr), 32'd0);
            chk("rst_data", wdata, 32'd0);
        end else begin
            chk("wen", 32'(wen), 32'(e.valid));
            chk("pvalid", 32'(pvalid), 32'(e.valid));
            if (e.valid) begin
                chk("waddr", 32'(waddr), 32'(e.addr));
                chk("wdata", wdata, e.data);
                chk("paddr", 32'(paddr), 32'(e.addr));
            end
        end
        chk("rdy0", 32'(rdy0), 32'(g0));
        chk("rdy1", 32'(rdy1), 32'(g1));
        n.valid = (g0 && a0 != 5'd0) || (g1 && a1 != 5'd0);
        n.addr  = g1 ? a1 : a0;
        n.data  = g1 ? d1 : d0;
        exp_q.push_back(n);
        @(posedge clk);
        if (rst) begin
            m_last   = 1'b1;
            m_streak = 0;
        end else begin
            if (g1 || !v1) m_streak = 0;
            else if (g0 && m_streak < MS) m_streak++;
            if (g0) m_last = 1'b0;
            else if (g1) m_last = 1'b1;
        end
        @(negedge clk);
        if (g0) v0 = 1'b0;
        if (g1) v1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        m_last = 1'b1; m_streak = 0;
        exp_q.push_back('0);
        step();
        step();
        rst = 1'b0;

        // R0 alone
        v0 = 1'b1; a0 = 5'd3; d0 = 32'hDEADBEEF;
        step();
        step();

        // conflict straight out of reset: R0 first, then held R1
        rst = 1'b1;
        step();
        rst = 1'b0;
        v0 = 1'b1; a0 = 5'd1; d0 = 32'h11;
        v1 = 1'b1; a1 = 5'd2; d1 = 32'h22;
        step();
        step();
        step();

        // both continuously valid with fresh data
        for (int i = 0; i < 8; i++) begin
            if (!v0) begin v0 = 1'b1; a0 = 5'(8 + i);  d0 = $urandom; end
            if (!v1) begin v1 = 1'b1; a1 = 5'(16 + i); d1 = $urandom; end
            #1;
            chk("alt_one_grant", 32'(rdy0 ^ rdy1), 32'd1);
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        step();

        // x0 write is accepted but not performed
        v0 = 1'b1; a0 = 5'd0; d0 = 32'h55;
        step();
        step();

        // R1 raised only after R0 grants, R0 always has fresh work
        for (int i = 0; i < 8; i++) begin
            if (!v0) begin v0 = 1'b1; a0 = 5'(1 + i); d0 = 32'h100 + 32'(i); end
            if (!v1 && m_last == 1'b0) begin v1 = 1'b1; a1 = 5'(20 + i); d1 = 32'h200 + 32'(i); end
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        step();

        // reset in the cycle after a handshake drops the write
        v0 = 1'b1; a0 = 5'd5; d0 = 32'h77;
        step();
        rst = 1'b1;
        v0 = 1'b1; a0 = 5'd9;  d0 = 32'h99;
        v1 = 1'b1; a1 = 5'd10; d1 = 32'hAA;
        step();
        rst = 1'b0;
        step();
        step();
        step();

        // same destination from both: later grant lands last
        v0 = 1'b1; a0 = 5'd7; d0 = 32'hA0A0;
        v1 = 1'b1; a1 = 5'd7; d1 = 32'hB1B1;
        step();
        step();
        step();

        chk("sb_drained", 32'(exp_q.size()), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
